// File: rtl/midi_wavetable_oscillator.sv
// MIDI-note phase-accumulator oscillator with saw/square/triangle/silent shapes,
// a linear gain ramp and a 3-stage sample pipeline (tick -> shape -> scale).
module midi_wavetable_oscillator #(
    parameter int CLK_HZ     = 50000000,
    parameter int SAMPLE_DIV = 1042,
    parameter int PHASE_W    = 32,
    parameter int OUT_W      = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    note_load,
    input  logic [6:0]              MIDI_note,
    input  logic [1:0]              mode,
    input  logic [6:0]              pulse_width,
    input  logic [6:0]              volume,
    input  logic                    gate,
    output logic                    sample_valid,
    output logic signed [OUT_W-1:0] value,
    output logic                    active
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    // Octave-10 phase increment for semitone k (C10 at k=0), rounded to nearest.
    function automatic logic [PHASE_W-1:0] rom_entry(input int k);
        real fs;
        real inc;
        fs  = real'(CLK_HZ) / real'(SAMPLE_DIV);
        inc = 440.0 * (2.0 ** (real'(k + 51) / 12.0)) * (2.0 ** PHASE_W) / fs;
        return PHASE_W'(longint'($floor(inc + 0.5)));
    endfunction

    function automatic logic signed [OUT_W-1:0] shape(input logic [1:0]         m,
                                                      input logic [PHASE_W-1:0] ph,
                                                      input logic [6:0]         pw);
        logic [OUT_W-1:0] p;
        logic [OUT_W-2:0] t;
        p = ph[PHASE_W-1 -: OUT_W];
        t = p[OUT_W-1] ? ~p[OUT_W-2:0] : p[OUT_W-2:0];
        case (m)
            2'd0:    return {~p[OUT_W-1], p[OUT_W-2:0]};
            2'd1:    return (ph[PHASE_W-1 -: 7] < pw) ? {1'b0, {(OUT_W-1){1'b1}}}
                                                      : {1'b1, {(OUT_W-1){1'b0}}};
            2'd2:    return {~t[OUT_W-2], t[OUT_W-3:0], 1'b0};
            default: return '0;
        endcase
    endfunction

    // Gain is Q0.7, so 127 scales by 127/128; the shift floors toward -inf.
    function automatic logic signed [OUT_W-1:0] scale(input logic signed [OUT_W-1:0] s,
                                                      input logic [6:0]              g);
        logic signed [OUT_W+7:0] prod;
        prod = s * $signed({1'b0, g});
        return prod[OUT_W+6:7];
    endfunction

    logic [PHASE_W-1:0] inc_rom [12];
    for (genvar k = 0; k < 12; k++) begin : g_rom
        localparam logic [PHASE_W-1:0] ENTRY = rom_entry(k);
        assign inc_rom[k] = ENTRY;
    end

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [6:0]         gain_q, gain_d;
    logic [6:0]         note_q, pw_q;
    logic [1:0]         mode_q;
    logic               vld_p1_q, vld_p2_q;
    logic signed [OUT_W-1:0] shaped_p2_q;

    logic               tick;
    logic [6:0]         target;
    logic [3:0]         semi, octave;
    logic [PHASE_W-1:0] inc;

    assign tick   = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
    assign target = gate ? volume : 7'd0;
    assign semi   = 4'(note_q % 7'd12);
    assign octave = 4'(note_q / 7'd12);
    assign inc    = inc_rom[semi] >> (4'd10 - octave);

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        phase_d = phase_q;
        gain_d  = gain_q;
        if (note_load) begin
            phase_d = '0;
        end else if (tick) begin
            phase_d = phase_q + inc;
        end
        if (tick && (gain_q < target)) begin
            gain_d = gain_q + 7'd1;
        end else if (tick && (gain_q > target)) begin
            gain_d = gain_q - 7'd1;
        end
    end

    // Stage 1: tick -> phase/gain update; stage 3: scale by gain into value.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            phase_q      <= '0;
            gain_q       <= '0;
            note_q       <= '0;
            mode_q       <= '0;
            pw_q         <= '0;
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            sample_valid <= 1'b0;
            value        <= '0;
            active       <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            gain_q   <= gain_d;
            if (note_load) begin
                note_q <= MIDI_note;
                mode_q <= mode;
                pw_q   <= pulse_width;
            end
            vld_p1_q     <= tick;
            vld_p2_q     <= vld_p1_q;
            sample_valid <= vld_p2_q;
            active       <= (gain_q != 7'd0);
            if (vld_p2_q) begin
                value <= scale(shaped_p2_q, gain_q);
            end
        end
    end

    // Stage 2: waveform shaping from the freshly updated phase.
    always_ff @(posedge clk) begin
        if (vld_p1_q) begin
            shaped_p2_q <= shape(mode_q, phase_q, pw_q);
        end
    end

endmodule

// File: tb/tb_midi_wavetable_oscillator.sv
// Bench for midi_wavetable_oscillator: directed phases plus random tail, checked
// sample-by-sample against an arithmetic model of phase, gain and waveform.
module tb_midi_wavetable_oscillator;

    localparam int     SDIV  = 20;
    localparam int     CLKHZ = 1000000;
    localparam longint FULL  = 64'sd8388608;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               note_load = 1'b0;
    logic [6:0]         MIDI_note = '0;
    logic [1:0]         mode = '0;
    logic [6:0]         pulse_width = '0;
    logic [6:0]         volume = '0;
    logic               gate = 1'b0;
    logic               sample_valid;
    logic signed [23:0] value;
    logic               active;

    int     passes = 0;
    int     total = 0;
    int     cyc = 0;
    int     last_cyc = 0;
    longint m_phase = 0;
    int     m_gain = 0, m_note = 0, m_mode = 0, m_pw = 0;
    bit     load_at_tick = 1'b0;

    midi_wavetable_oscillator #(
        .CLK_HZ(CLKHZ), .SAMPLE_DIV(SDIV), .PHASE_W(32), .OUT_W(24)
    ) dut (
        .clk(clk), .reset(reset), .note_load(note_load), .MIDI_note(MIDI_note),
        .mode(mode), .pulse_width(pulse_width), .volume(volume), .gate(gate),
        .sample_valid(sample_valid), .value(value), .active(active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint ref_inc(input int note);
        real    fs;
        real    f;
        longint entry;
        fs    = real'(CLKHZ) / real'(SDIV);
        f     = 440.0 * 2.0 ** (real'(note % 12 + 51) / 12.0) * 4294967296.0 / fs;
        entry = longint'($floor(f + 0.5));
        return entry >> (10 - note / 12);
    endfunction

    function automatic longint ref_value();
        longint p;
        longint s;
        p = m_phase >> 8;
        case (m_mode)
            0:       s = p - FULL;
            1:       s = ((m_phase >> 25) < m_pw) ? FULL - 1 : -FULL;
            2:       s = 2 * ((p < FULL) ? p : (2 * FULL - 1 - p)) - FULL;
            default: s = 0;
        endcase
        return (s * m_gain) >>> 7;
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic model_tick();
        int target;
        target = gate ? int'(volume) : 0;
        if (load_at_tick) begin
            m_phase      = 0;
            load_at_tick = 1'b0;
        end else begin
            m_phase = (m_phase + ref_inc(m_note)) & 64'hFFFF_FFFF;
        end
        if (m_gain < target) m_gain++;
        else if (m_gain > target) m_gain--;
    endtask

    task automatic get_sample(input string tag, input bit chk_gap);
        bit found;
        found = 1'b0;
        for (int i = 0; i < SDIV + 8; i++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, " strobe"}, longint'(found), 1);
        if (found) begin
            model_tick();
            check({tag, " value"}, longint'(value), ref_value());
            check({tag, " active"}, longint'(active), longint'(m_gain != 0));
            if (chk_gap) check({tag, " gap"}, longint'(cyc - last_cyc), SDIV);
            last_cyc = cyc;
        end
    endtask

    task automatic do_load(input int note, input int md, input int pw, input bit at_tick);
        note_load   = 1'b1;
        MIDI_note   = 7'(note);
        mode        = 2'(md);
        pulse_width = 7'(pw);
        m_note = note;
        m_mode = md;
        m_pw   = pw;
        if (at_tick) load_at_tick = 1'b1;
        else m_phase = 0;
        @(negedge clk);
        note_load = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        int lat;
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        check("rst valid", longint'(sample_valid), 0);
        check("rst value", longint'(value), 0);
        check("rst active", longint'(active), 0);
        reset = 1'b0;
        m_phase = 0; m_gain = 0; m_note = 0; m_mode = 0; m_pw = 0;
        load_at_tick = 1'b0;
        lat = 0;
        for (int k = 1; k <= SDIV + 8; k++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("first latency", longint'(lat), SDIV + 2);
        if (lat != 0) begin
            model_tick();
            check("first value", longint'(value), ref_value());
            check("first active", longint'(active), longint'(m_gain != 0));
            last_cyc = cyc;
        end
    endtask

    initial begin
        int pos;
        // Reset with no inputs.
        do_reset(3);

        // Saw, note 69, gain ramp to full.
        volume = 7'd127;
        gate   = 1'b1;
        do_load(69, 0, 0, 1'b0);
        for (int i = 0; i < 130; i++) get_sample("saw", 1'b1);

        // Square, 25% duty.
        do_load(60, 1, 32, 1'b0);
        pos = 0;
        for (int i = 0; i < 191; i++) begin
            get_sample("square", 1'b1);
            if (value > 0) pos++;
        end
        check("square duty", longint'(pos >= 40 && pos <= 56), 1);

        // Triangle.
        do_load(81, 2, 0, 1'b0);
        for (int i = 0; i < 60; i++) get_sample("tri", 1'b1);

        // Load in the tick cycle itself.
        repeat (SDIV - 3) @(negedge clk);
        do_load(72, 0, 0, 1'b1);
        get_sample("coinc", 1'b1);
        check("coinc phase0", longint'(value), -64'sd8323072);
        for (int i = 0; i < 5; i++) get_sample("coinc run", 1'b1);

        // Release: linear decay to zero, then active drops one cycle later.
        gate = 1'b0;
        for (int i = 0; i < 126; i++) get_sample("decay", 1'b1);
        repeat (SDIV - 2) @(negedge clk);
        check("active hold", longint'(active), 1);
        @(negedge clk);
        check("active fall", longint'(active), 0);
        get_sample("decay end", 1'b1);

        // Silent mode.
        gate   = 1'b1;
        volume = 7'd100;
        do_load(50, 3, 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            get_sample("silent", 1'b1);
            check("silent zero", longint'(value), 0);
        end

        // Reset while a sample is in flight.
        volume = 7'd127;
        do_load(64, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) get_sample("pre-rst", 1'b1);
        repeat (SDIV - 2) @(negedge clk);
        do_reset(2);

        // Random notes, shapes, volume and gate.
        for (int i = 0; i < 150; i++) begin
            get_sample("rnd", 1'b1);
            if ($urandom_range(0, 5) == 0)
                do_load(int'($urandom_range(0, 127)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 127)), 1'b0);
            if ($urandom_range(0, 3) == 0) volume = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 9) == 0) gate = ~gate;
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
